// File: rtl/shot_pkg.sv
// shot_pkg: types and constants shared by the shot scheduler and the shot datapaths
package shot_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_ACK, COOLDOWN} state_t;
    localparam int DEF_NUM_SLOTS = 4;
    typedef logic [$clog2(DEF_NUM_SLOTS)-1:0] slot_idx_t;
    localparam int FIXED_POINT_MULTIPLIER = 64;
endpackage

// File: rtl/shot_slot_tracker.sv
// shot_slot_tracker: per-slot busy flag and lifetime counter, raising kill on expiry or ack timeout
module shot_slot_tracker #(
    parameter int MAX_LIFE_FRAMES = 90
) (
    input  logic clk,
    input  logic resetN,
    input  logic start,
    input  logic frame,
    input  logic collision,
    input  logic ack_kill,
    output logic busy,
    output logic kill
);
    localparam int LW = $clog2(MAX_LIFE_FRAMES + 1);
    logic [LW-1:0] life;
    logic expire;
    assign expire = frame && life == LW'(MAX_LIFE_FRAMES - 1);
    // a collision retires the slot quietly, even when it coincides with expiry
    assign kill = busy && !collision && (expire || ack_kill);
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            busy <= 1'b0;
            life <= '0;
        end else if (start) begin
            busy <= 1'b1;
            life <= '0;
        end else if (busy) begin
            busy <= !(collision || kill);
            if (frame) life <= life + 1'b1;
        end
    end
endmodule

// File: rtl/shot_scheduler.sv
// shot_scheduler: turns fire presses into round-robin slot launches with ammo, cooldown and retirement
module shot_scheduler
    import shot_pkg::*;
#(
    parameter int NUM_SLOTS       = DEF_NUM_SLOTS,
    parameter int MAX_AMMO        = 10,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MAX_LIFE_FRAMES = 90,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic                             clk,
    input  logic                             resetN,
    input  logic                             startOfFrame,
    input  logic                             fireReq,
    input  logic                             reloadReq,
    input  logic [NUM_SLOTS-1:0]             slotEnable,
    input  logic [NUM_SLOTS-1:0]             slotCollision,
    output logic [NUM_SLOTS-1:0]             slotStart,
    output logic [NUM_SLOTS-1:0]             slotKill,
    output logic [NUM_SLOTS-1:0]             slotBusy,
    output logic [$clog2(MAX_AMMO+1)-1:0]    ammoCount,
    output logic                             cooldownBusy,
    output logic                             shotFired,
    output logic                             ackError
);
    localparam int SW = $clog2(NUM_SLOTS);
    localparam int AW = $clog2(MAX_AMMO + 1);
    localparam int KW = $clog2(ACK_TIMEOUT + 1);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [AW-1:0] AMMO_FULL = AW'(MAX_AMMO);
    state_t state, next_state;
    logic fire_d, fire_edge, launched, no_free, timeout, en_sel, col_sel, ack_last;
    logic [SW-1:0] sel, rr_ptr, pick;
    logic [NUM_SLOTS-1:0] busy, rot, sel_oh, ack_kill;
    logic [KW-1:0] ack_cnt;
    logic [CW-1:0] cd_cnt;
    int first;
    assign slotBusy = busy;
    assign sel_oh = NUM_SLOTS'(1) << sel;
    assign en_sel = |(slotEnable & sel_oh);
    assign col_sel = |(slotCollision & sel_oh);
    assign ack_last = ack_cnt == KW'(ACK_TIMEOUT - 1);
    // rotate so bit 0 is the first candidate; the first search after reset starts at slot 0
    always_comb begin
        first = launched ? int'(rr_ptr) + 1 : 0;
        rot = NUM_SLOTS'({busy, busy} >> first);
        pick = '0;
        no_free = 1'b1;
        for (int k = NUM_SLOTS - 1; k >= 0; k--)
            if (!rot[k]) begin
                pick = SW'((first + k) % NUM_SLOTS);
                no_free = 1'b0;
            end
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (fire_edge && ammoCount != '0 && !no_free) next_state = LAUNCH;
            LAUNCH:   next_state = WAIT_ACK;
            WAIT_ACK: if (en_sel || col_sel || ack_last) next_state = COOLDOWN;
            COOLDOWN: if (startOfFrame && cd_cnt == CW'(COOLDOWN_FRAMES - 1)) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end
    always_comb begin
        timeout = state == WAIT_ACK && !en_sel && !col_sel && ack_last;
        slotStart = state == LAUNCH ? sel_oh : '0;
        shotFired = state == LAUNCH;
        ackError = timeout;
        ack_kill = timeout ? sel_oh : '0;
        cooldownBusy = state != IDLE;
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fire_d <= 1'b0;
            fire_edge <= 1'b0;
            launched <= 1'b0;
            sel <= '0;
            rr_ptr <= '0;
            ammoCount <= AMMO_FULL;
            ack_cnt <= '0;
            cd_cnt <= '0;
        end else begin
            fire_d <= fireReq;
            fire_edge <= fireReq && !fire_d;
            if (state == IDLE) sel <= pick;
            if (state == LAUNCH) begin
                rr_ptr <= sel;
                launched <= 1'b1;
            end
            ammoCount <= reloadReq ? AMMO_FULL : state == LAUNCH ? ammoCount - 1'b1 : ammoCount;
            ack_cnt <= state == WAIT_ACK ? ack_cnt + 1'b1 : '0;
            cd_cnt <= state != COOLDOWN ? '0 : startOfFrame ? cd_cnt + 1'b1 : cd_cnt;
        end
    end
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        shot_slot_tracker #(.MAX_LIFE_FRAMES(MAX_LIFE_FRAMES)) u_trk (
            .clk(clk),
            .resetN(resetN),
            .start(slotStart[g]),
            .frame(startOfFrame),
            .collision(slotCollision[g]),
            .ack_kill(ack_kill[g]),
            .busy(busy[g]),
            .kill(slotKill[g])
        );
    end
endmodule

// File: tb/tb_shot_scheduler.sv
// tb_shot_scheduler: directed and random stimulus scored against a frame/slot level reference model
module tb_shot_scheduler;
    localparam int N = 4, MAX_AMMO = 10, CD = 8, LIFE = 90, ACK = 16;
    logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, fireReq = 1'b0, reloadReq = 1'b0;
    logic [N-1:0] slotEnable = '0, slotCollision = '0;
    logic [N-1:0] slotStart, slotKill, slotBusy;
    logic [3:0] ammoCount;
    logic cooldownBusy, shotFired, ackError;
    always #5 clk = ~clk;
    shot_scheduler dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
        .reloadReq(reloadReq), .slotEnable(slotEnable), .slotCollision(slotCollision),
        .slotStart(slotStart), .slotKill(slotKill), .slotBusy(slotBusy), .ammoCount(ammoCount),
        .cooldownBusy(cooldownBusy), .shotFired(shotFired), .ackError(ackError)
    );
    typedef struct {int cyc; logic [N-1:0] start; logic [N-1:0] kill; logic err;} ev_t;
    ev_t q[$];
    int tests = 0, fails = 0, cyc = 0;
    typedef enum {READY, LAUNCHING, ACKING, COOLING} phase_t;
    phase_t ph;
    int ammo, last, cur, ack_left, cool_left;
    int age[N];
    bit busy[N];
    bit fire_prev, edge_seen;
    logic [N-1:0] exp_busy;
    int exp_ammo;
    bit exp_cd;
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    task automatic model_reset();
        ph = READY;
        ammo = MAX_AMMO;
        last = -1;
        cur = 0;
        fire_prev = 0;
        edge_seen = 0;
        for (int i = 0; i < N; i++) begin
            busy[i] = 0;
            age[i] = 0;
        end
    endtask
    // one clock of the reference: publish visible state, queue expected pulses, then advance
    task automatic model_step();
        logic [N-1:0] st, kl;
        bit to, found;
        phase_t p0;
        if (!resetN) model_reset();
        for (int i = 0; i < N; i++) exp_busy[i] = busy[i];
        exp_ammo = ammo;
        exp_cd = ph != READY;
        if (!resetN) return;
        p0 = ph;
        st = '0;
        kl = '0;
        to = p0 == ACKING && !slotEnable[cur] && !slotCollision[cur] && ack_left == 1;
        if (p0 == LAUNCHING) st[cur] = 1'b1;
        for (int i = 0; i < N; i++)
            if (busy[i] && !slotCollision[i] && ((startOfFrame && age[i] == LIFE - 1) || (to && i == cur)))
                kl[i] = 1'b1;
        if (st != 0 || kl != 0 || to) q.push_back('{cyc, st, kl, to});
        case (p0)
            READY: begin
                found = 0;
                for (int k = 0; k < N && !found; k++) begin
                    int s = (last + 1 + k) % N;
                    if (!busy[s]) begin
                        cur = s;
                        found = 1;
                    end
                end
                if (edge_seen && ammo > 0 && found) ph = LAUNCHING;
            end
            LAUNCHING: begin
                last = cur;
                ph = ACKING;
                ack_left = ACK;
            end
            ACKING: begin
                if (slotEnable[cur] || slotCollision[cur] || ack_left == 1) begin
                    ph = COOLING;
                    cool_left = CD;
                end else ack_left--;
            end
            COOLING: begin
                if (startOfFrame) begin
                    cool_left--;
                    if (cool_left == 0) ph = READY;
                end
            end
        endcase
        ammo = reloadReq ? MAX_AMMO : ammo - (p0 == LAUNCHING ? 1 : 0);
        for (int i = 0; i < N; i++)
            if (p0 == LAUNCHING && i == cur) begin
                busy[i] = 1;
                age[i] = 0;
            end else if (busy[i]) begin
                if (slotCollision[i] || kl[i]) busy[i] = 0;
                else if (startOfFrame) age[i]++;
            end
        edge_seen = fireReq && !fire_prev;
        fire_prev = fireReq;
    endtask
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    task automatic idle(int n);
        repeat (n) tick();
    endtask
    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        idle(2);
    endtask
    task automatic pull();
        fireReq = 1'b1;
        tick();
        fireReq = 1'b0;
        tick();
    endtask
    task automatic free_all();
        slotCollision = '1;
        tick();
        slotCollision = '0;
    endtask
    task automatic shoot(logic [N-1:0] ack_bits);
        pull();
        idle(2);
        slotEnable = slotEnable | ack_bits;
        idle(ack_bits == 0 ? ACK + 2 : 2);
        repeat (CD + 1) frame();
    endtask
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            check("slotBusy", slotBusy, exp_busy);
            check("ammoCount", ammoCount, exp_ammo);
            check("cooldownBusy", cooldownBusy, exp_cd);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                tests++;
                fails++;
                if (fails <= 30) $display("FAIL missing_event cyc=%0d got none expected start=%b kill=%b err=%b", e.cyc, e.start, e.kill, e.err);
            end
            if ((slotStart | slotKill) != 0 || shotFired || ackError) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    if (fails <= 30) $display("FAIL unexpected_event cyc=%0d got start=%b kill=%b fired=%b err=%b expected none", cyc, slotStart, slotKill, shotFired, ackError);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("slotStart", slotStart, e.start);
                    check("slotKill", slotKill, e.kill);
                    check("shotFired", shotFired, e.start != 0);
                    check("ackError", ackError, e.err);
                end
            end
        end
    end
    initial begin
        model_reset();
        @(posedge clk);
        #1;
        idle(3);
        resetN = 1'b1;
        idle(2);
        shoot(4'b0001);
        shoot(4'b0010);
        shoot(4'b0100);
        shoot(4'b1000);
        pull();
        idle(4);
        slotCollision = 4'b0100;
        tick();
        slotCollision = '0;
        slotEnable = 4'b1011;
        shoot(4'b0100);
        repeat (6) begin
            free_all();
            shoot('1);
        end
        reloadReq = 1'b1;
        tick();
        reloadReq = 1'b0;
        free_all();
        fireReq = 1'b1;
        tick();
        fireReq = 1'b0;
        tick();
        reloadReq = 1'b1;
        tick();
        reloadReq = 1'b0;
        repeat (CD + 1) frame();
        free_all();
        slotEnable = '0;
        shoot('0);
        free_all();
        shoot('1);
        repeat (LIFE) frame();
        free_all();
        shoot('1);
        repeat (LIFE) if (busy[last] && age[last] < LIFE - 1) frame();
        startOfFrame = 1'b1;
        slotCollision = N'(1) << last;
        tick();
        startOfFrame = 1'b0;
        slotCollision = '0;
        idle(2);
        free_all();
        slotEnable = '0;
        pull();
        idle(2);
        resetN = 1'b0;
        idle(2);
        resetN = 1'b1;
        idle(2);
        repeat (12000) begin
            if ($urandom_range(0, 5) == 0) fireReq = ~fireReq;
            startOfFrame = $urandom_range(0, 3) == 0;
            reloadReq = $urandom_range(0, 399) == 0;
            slotEnable = N'($urandom) & N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) slotCollision[i] = $urandom_range(0, 47) == 0;
            resetN = $urandom_range(0, 1999) != 0;
            tick();
        end
        resetN = 1'b1;
        fireReq = 1'b0;
        startOfFrame = 1'b0;
        reloadReq = 1'b0;
        slotEnable = '0;
        slotCollision = '0;
        idle(3);
        while (q.size() > 0) begin
            tests++;
            fails++;
            if (fails <= 30) $display("FAIL leftover_event expected cyc=%0d start=%b kill=%b got none", q[0].cyc, q[0].start, q[0].kill);
            void'(q.pop_front());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/shot_scheduler.md
Name: shot_scheduler

Overview:
- Sequences player shots across a pool of NUM_SLOTS shot-trajectory datapaths.
- Converts the fire button into per-slot launch pulses, enforcing ammo, a frame-based cooldown, and round-robin slot allocation.
- Retires slots on collision or lifetime expiry.
- Sits between the player-input logic and the shot datapath instances; feeds slot status to the renderer/HUD.

Parameters:
- NUM_SLOTS, 4, number of shot datapath instances managed (2..8).
- MAX_AMMO, 10, ammo loaded at reset and on reload.
- COOLDOWN_FRAMES, 8, startOfFrame pulses between consecutive launches.
- MAX_LIFE_FRAMES, 90, frames a shot may live before forced retirement.
- ACK_TIMEOUT, 16, clk cycles to wait for the datapath's enable after launch.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- fireReq  in  1  fire button level (already synchronised)
- reloadReq  in  1  one-cycle pulse, refill ammo
- slotEnable  in  NUM_SLOTS  per-slot "shot in flight" status from datapaths
- slotCollision  in  NUM_SLOTS  per-slot hit pulse
- slotStart  out  NUM_SLOTS  one-hot one-cycle launch pulse
- slotKill  out  NUM_SLOTS  one-cycle forced-retire pulse (lifetime expiry / ack timeout)
- slotBusy  out  NUM_SLOTS  slot allocated
- ammoCount  out  $clog2(MAX_AMMO+1)  remaining shots
- cooldownBusy  out  1  high while not in IDLE
- shotFired  out  1  one-cycle pulse per launch
- ackError  out  1  one-cycle pulse on ack timeout

Behaviour:
- Reset values:
  - state IDLE.
  - All pulse outputs, slotBusy and cooldownBusy 0.
  - ammoCount = MAX_AMMO; rrPtr = 0; all counters 0.
  - fireReq edge register 0.
- Fire detection: registered rising edge of fireReq (fireEdge = fireReq & ~fireReq_d). fireEdge outside IDLE is dropped, not queued.
- Slot selection: combinational search for the first free slot (slotBusy==0) starting at rrPtr+1 modulo NUM_SLOTS, wrapping. "noFree" when all slots are busy.
- FSM:
  - IDLE: on fireEdge with ammoCount>0 and !noFree, latch sel, go LAUNCH. If ammo==0 or noFree, stay IDLE with no output.
  - LAUNCH (1 cycle):
    - slotStart[sel]=1, slotBusy[sel]<=1, life[sel]<=0.
    - ammoCount<=ammoCount-1, shotFired=1.
    - rrPtr<=sel, ackCnt<=0; go WAIT_ACK.
  - WAIT_ACK:
    - slotEnable[sel]=1 -> COOLDOWN.
    - slotCollision[sel] -> release slot, go COOLDOWN.
    - ackCnt reaches ACK_TIMEOUT-1 without either -> slotKill[sel]=1, slotBusy[sel]<=0, ackError=1, go COOLDOWN.
  - COOLDOWN: cdCnt<=0 on entry; increments on each startOfFrame. When cdCnt==COOLDOWN_FRAMES-1 and startOfFrame -> IDLE.
- Latency: fireEdge registered in cycle N -> slotStart in cycle N+2 (IDLE decision, then LAUNCH).
- Lifetime:
  - For each busy slot, life[i] increments on startOfFrame; width $clog2(MAX_LIFE_FRAMES+1).
  - When life[i]==MAX_LIFE_FRAMES-1 and startOfFrame: slotKill[i]=1, slotBusy[i]<=0.
- Collision: slotCollision[i] on a busy slot -> slotBusy[i]<=0 next cycle, no slotKill. Collision on a free slot is ignored.
- Simultaneous events:
  - Collision and expiry on the same slot in the same cycle: collision wins, no slotKill.
  - reloadReq in the same cycle as the LAUNCH decrement: ammoCount=MAX_AMMO (reload wins).
  - A slot released in the same cycle a search runs is not visible until the next cycle.
- Multiple slots may retire in the same cycle, independently.
- Reset mid-operation: all slots return to free immediately; no slotKill is emitted.

Decomposition:
- Shared package shot_pkg:
  - state enum (IDLE, LAUNCH, WAIT_ACK, COOLDOWN)
  - slot-index typedef sized $clog2(NUM_SLOTS)
  - FIXED_POINT_MULTIPLIER shared with the datapaths
- Sub-module shot_slot_tracker (instantiated NUM_SLOTS times) owns busy and life counters, and generates kill/release.
- The top level holds the FSM, ammo, cooldown and round-robin picker.

Test Plan:
- Reset, fireReq rising edge -> slotStart=0001 two cycles after the edge; ammoCount 10->9; shotFired one pulse; cooldownBusy high.
- Hold slotEnable[0]=1, send 8 startOfFrame pulses -> IDLE. Next fire -> slotStart=0010; then 0100, 1000, then wrap to first free.
- Four slots busy, fire after cooldown -> no slotStart, ammo unchanged. Then pulse slotCollision[2] -> next fire launches slot 2.
- Fire 10 times with cooldown elapsed -> ammoCount=0, and an 11th fire is ignored. Then reloadReq coincident with a launch -> ammoCount=10.
- Launch, never assert slotEnable -> after 16 cycles slotKill[sel]=1, ackError=1, slotBusy[sel]=0.
- Launch with ack, then 90 startOfFrame with no collision -> slotKill pulse on the 90th frame. Repeat with collision and expiry in the same cycle -> no slotKill. Assert resetN low mid-WAIT_ACK -> all outputs at reset values.
